// File: rtl/hdmi_di_pkg.sv
`default_nettype none
// ============================================================================
// hdmi_di_pkg : shared types and constants for the HDMI data-island generator
// Revision    : 1.0
// ============================================================================
package hdmi_di_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_LGUARD   = 3'd2,
    ST_PACKET   = 3'd3,
    ST_TGUARD   = 3'd4
  } di_state_e;

  localparam logic [7:0] BCH_POLY     = 8'h83;
  localparam logic [3:0] PREAMBLE_CTL = 4'b0101;
  localparam logic [1:0] GUARD_NIBBLE = 2'b11;
  localparam int         PKT_PIXELS   = 32;
  localparam int         HDR_BITS     = 24;
  localparam int         SUB_BITS     = 56;
  localparam int         SUBPKTS      = 4;
  localparam int         BODY_BITS    = SUB_BITS * SUBPKTS;

  // One serial BCH step: LSB-first shift with feedback polynomial.
  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    logic fb;
    fb = e[0] ^ b;
    return (e >> 1) ^ (fb ? BCH_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_data_island_if.sv
`default_nettype none
// ============================================================================
// hdmi_data_island_if : packet handshake and TERC4 symbol bundle
// Revision            : 1.0
// ============================================================================
interface hdmi_data_island_if;
  import hdmi_di_pkg::*;

  logic                 start;
  logic                 hsync;
  logic                 vsync;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [HDR_BITS-1:0]  pkt_header;
  logic [BODY_BITS-1:0] pkt_body;
  logic                 busy;
  logic [3:0]           ctl;
  logic                 data_en;
  logic                 guard;
  logic [3:0]           ch0;
  logic [3:0]           ch1;
  logic [3:0]           ch2;

  modport master (
    output start, hsync, vsync, pkt_valid, pkt_header, pkt_body,
    input  pkt_ready, busy, ctl, data_en, guard, ch0, ch1, ch2
  );

  modport slave (
    input  start, hsync, vsync, pkt_valid, pkt_header, pkt_body,
    output pkt_ready, busy, ctl, data_en, guard, ch0, ch1, ch2
  );

endinterface
`default_nettype wire

// File: rtl/hdmi_bch_lfsr.sv
`default_nettype none
// ============================================================================
// hdmi_bch_lfsr : 8-bit BCH parity accumulator, BITS_PER_CLK bits per cycle
// Revision      : 1.0
// ============================================================================
module hdmi_bch_lfsr
  import hdmi_di_pkg::*;
#(
  parameter int BITS_PER_CLK = 1
) (
  input  wire                    pixclk,
  input  wire                    rst_n,
  input  wire                    clear,
  input  wire                    advance,
  input  wire [BITS_PER_CLK-1:0] data,
  output logic [7:0]             parity
);

  logic [7:0] ecc_q, ecc_d;

  always_comb begin
    ecc_d = ecc_q;
    if (clear) begin
      ecc_d = '0;
    end else if (advance) begin
      for (int i = 0; i < BITS_PER_CLK; i++) begin
        ecc_d = bch_step(ecc_d, data[i]);
      end
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) ecc_q <= '0;
    else        ecc_q <= ecc_d;
  end

  assign parity = ecc_q;

endmodule
`default_nettype wire

// File: rtl/hdmi_data_island.sv
`default_nettype none
// ============================================================================
// hdmi_data_island : preamble, guard bands and BCH-protected packet slots.
// Option HDMI_DI_NULL_FILL_EN pads unoffered slots with null packets.
// Revision         : 1.0
// ============================================================================
module hdmi_data_island
  import hdmi_di_pkg::*;
#(
  parameter int NUM_PACKETS  = 2,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input wire                pixclk,
  input wire                rst_n,
  hdmi_data_island_if.slave di
);

  localparam int CNT_MAX = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SLOT_W  = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

  di_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            pix_q, pix_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  start_pend_q, start_pend_d;
  logic [HDR_BITS-1:0]   hdr_q, hdr_d;
  logic [BODY_BITS-1:0]  body_q, body_d;

  logic                  in_pkt, pix_last, slot_last, guard_last, load, take;
  logic [7:0]            hdr_ecc;
  logic [7:0]            sub_ecc [SUBPKTS];
  logic [31:0]           hdr_word;
  logic [SUBPKTS-1:0]    ch1_bits, ch2_bits;

  assign in_pkt     = (state_q == ST_PACKET);
  assign pix_last   = (pix_q == 5'(PKT_PIXELS - 1));
  assign slot_last  = (slot_q == SLOT_W'(NUM_PACKETS - 1));
  assign guard_last = (cnt_q == CNT_W'(GUARD_LEN - 1));
  // A slot is (re)loaded on the cycle before its first pixel, offered or not.
  assign load       = ((state_q == ST_LGUARD) && guard_last) || (in_pkt && pix_last && !slot_last);
  assign take       = load & di.pkt_valid;
  assign hdr_word   = {hdr_ecc, hdr_q};

  hdmi_bch_lfsr #(.BITS_PER_CLK(1)) u_hdr_bch (
    .pixclk  (pixclk),
    .rst_n   (rst_n),
    .clear   (load),
    .advance (in_pkt && (pix_q < 5'(HDR_BITS))),
    .data    (hdr_word[pix_q]),
    .parity  (hdr_ecc)
  );

  for (genvar n = 0; n < SUBPKTS; n++) begin : g_sub
    logic [63:0] word;
    assign word = {sub_ecc[n], body_q[n*SUB_BITS +: SUB_BITS]};

    hdmi_bch_lfsr #(.BITS_PER_CLK(2)) u_sub_bch (
      .pixclk  (pixclk),
      .rst_n   (rst_n),
      .clear   (load),
      .advance (in_pkt && (pix_q < 5'(SUB_BITS / 2))),
      .data    (word[{pix_q, 1'b0} +: 2]),
      .parity  (sub_ecc[n])
    );

    assign ch1_bits[n] = word[{pix_q, 1'b0}];
    assign ch2_bits[n] = word[{pix_q, 1'b1}];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pix_d        = pix_q;
    slot_d       = slot_q;
    hdr_d        = hdr_q;
    body_d       = body_q;
    start_pend_d = di.start & (state_q == ST_IDLE);

    if (load) begin
      hdr_d  = take ? di.pkt_header : '0;
      body_d = take ? di.pkt_body   : '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_pend_q) begin
          state_d = ST_PREAMBLE;
          cnt_d   = '0;
        end
      end
      ST_PREAMBLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
          state_d = ST_LGUARD;
          cnt_d   = '0;
        end
      end
      ST_LGUARD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (guard_last) begin
          state_d = ST_PACKET;
          cnt_d   = '0;
          pix_d   = '0;
          slot_d  = '0;
        end
      end
      ST_PACKET: begin
        pix_d = pix_q + 5'd1;
        if (pix_last) begin
          if (slot_last) begin
            state_d = ST_TGUARD;
          end else begin
`ifdef HDMI_DI_NULL_FILL_EN
            slot_d = slot_q + SLOT_W'(1);
`else
            // Without padding the first unoffered later slot closes the island.
            if (take) slot_d  = slot_q + SLOT_W'(1);
            else      state_d = ST_TGUARD;
`endif
          end
        end
      end
      ST_TGUARD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (guard_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pix_q        <= '0;
      slot_q       <= '0;
      start_pend_q <= 1'b0;
      hdr_q        <= '0;
      body_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pix_q        <= pix_d;
      slot_q       <= slot_d;
      start_pend_q <= start_pend_d;
      hdr_q        <= hdr_d;
      body_q       <= body_d;
    end
  end

  // Sync levels pass straight through so they align with the symbols.
  always_comb begin
    di.pkt_ready = load;
    di.busy      = (state_q != ST_IDLE);
    di.ctl       = (state_q == ST_PREAMBLE) ? PREAMBLE_CTL : 4'h0;
    di.guard     = (state_q == ST_LGUARD) || (state_q == ST_TGUARD);
    di.data_en   = di.guard || in_pkt;
    di.ch0       = 4'h0;
    di.ch1       = 4'h0;
    di.ch2       = 4'h0;
    if (di.guard) begin
      di.ch0 = {GUARD_NIBBLE, di.vsync, di.hsync};
    end else if (in_pkt) begin
      di.ch0 = {(pix_q != 5'd0), hdr_word[pix_q], di.vsync, di.hsync};
      di.ch1 = ch1_bits;
      di.ch2 = ch2_bits;
    end
  end

endmodule
`default_nettype wire

// File: doc/hdmi_data_island.md
# hdmi_data_island

- Generates the HDMI data-island period for `NUM_PACKETS` packets: control preamble, leading guard band, packet payloads with BCH parity, and trailing guard band.
- Each cycle it emits per-channel 4-bit TERC4 symbols and control/guard flags.
- It sits in the pixel-clock domain between packet sources (InfoFrame/audio builders) and the TMDS/TERC4 encoders and serialisers; the video timing generator triggers it during horizontal blanking.

## Interface
- `NUM_PACKETS`, default 2: packet slots per island, 1..18.
- `PREAMBLE_LEN`, default 8: data preamble cycles.
- `GUARD_LEN`, default 2: guard-band cycles at each end of the island.
- `pixclk  in  1`: pixel clock. One clock; all logic in this domain.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: one-cycle pulse that begins an island; ignored while `busy`.
- `hsync`, `vsync  in  1 each`: current sync levels, carried on channel 0 bits [1:0].
- `pkt_valid  in  1`: source offers a packet.
- `pkt_ready  out  1`: packet accepted this cycle when `pkt_valid` is also high.
- `pkt_header  in  24`: HB0..HB2, bit 0 = HB0[0].
- `pkt_body  in  224`: subpackets 0..3, 56 bits each; subpacket n occupies [56n+55:56n].
- `busy  out  1`: island in progress.
- `ctl  out  4`: CTL3..CTL0; 4'b0101 during preamble, else 0.
- `data_en  out  1`: TERC4 data period, covering guards and packets.
- `guard  out  1`: guard-band cycle.
- `ch0`, `ch1`, `ch2  out  4 each`: TERC4 nibbles.

## Operation
- States: IDLE → PREAMBLE (`PREAMBLE_LEN`) → LGUARD (`GUARD_LEN`) → PACKET (32 per slot) → TGUARD (`GUARD_LEN`) → IDLE.
- Packet loading:
  - `pkt_ready` is high on the final LGUARD cycle and on pixel k=31 of every slot except the last.
  - A handshake on that cycle loads the next slot.
  - With no handshake, the slot carries a null packet (all zeros).
- Guard cycles: `ch0`={1,1,vsync,hsync}. `ch1`/`ch2` are don't-care; the downstream mux substitutes guard codes.
- Packet pixel k (0..31):
  - `ch0`={k!=0, H[k], vsync, hsync}, where H = {hdr_ecc, pkt_header}.
  - `ch1[n]` = S_n[2k] and `ch2[n]` = S_n[2k+1], where S_n = {ecc_n, subpacket n}.
- BCH: an 8-bit LFSR per code word, fed LSB-first.
  - Each bit b: fb = e[0]^b; e = e>>1; if fb, e ^= 8'h83.
  - The header LFSR takes 24 bits at 1 bit/clk. The subpacket LFSRs take 56 bits at 2 bits/clk.
  - Parity is emitted LSB-first at k=24..31 (header) and k=28..31 (subpackets).
- IDLE outputs: ctl=0, data_en=0, guard=0, ch*=0.

## Timing
- Reset value of every output is 0. `pkt_ready`=0 in reset.
- A `start` sampled at edge t makes `busy`=1 and PREAMBLE outputs valid after edge t+1.
- PREAMBLE_LEN=8, GUARD_LEN=2, NUM_PACKETS=2 gives:
  - LGUARD at cycles 9..10.
  - Packet k=0 at cycle 11.
  - TGUARD at cycles 75..76.
  - IDLE at cycle 77.
- Total island = `PREAMBLE_LEN` + 2·`GUARD_LEN` + 32·`NUM_PACKETS` cycles.
- A `start` coinciding with the final TGUARD cycle is ignored.
- `rst_n` low mid-island aborts immediately: outputs 0, state IDLE, the in-flight packet is dropped.
- hsync/vsync are sampled combinationally into `ch0`, so their latency is 0 relative to the registered symbols.

## Configuration
- `HDMI_DI_NULL_FILL_EN` defined: empty slots are filled with null packets, so island length is always fixed.
- Undefined:
  - Slot 0 is always sent (null if no packet).
  - A later slot with no handshake ends the island: TGUARD follows immediately after k=31 of the previous slot.

## Structure
- Package `hdmi_di_pkg` holds:
  - state enum;
  - `BCH_POLY`=8'h83;
  - preamble code 4'b0101;
  - guard nibble;
  - `PKT_PIXELS`=32;
  - header/subpacket widths.
- Sub-module `hdmi_bch_lfsr`: parameter `BITS_PER_CLK` (1 or 2), with clear, advance and data inputs and an 8-bit parity output. It is instantiated 5 times.

## Test plan
- Reset then `start` with no `pkt_valid` → 8 cycles ctl=4'b0101, then 2 guard cycles with ch0=4'b11{vs,hs}. Packet k=0 ch0=4'b00{vs,hs}, k≥1 ch0[3]=1, all ECC bits 0.
- header=24'h000001, body=0 → hdr_ecc=8'h4A. ch0[2] over k=24..31 = 0,1,0,1,0,0,1,0.
- Subpacket 0 = 56'h1 → ch1[0] at k=0 is 1. Bits 28..31 of `ch1[0]`/`ch2[0]` match the bench LFSR model; subpackets 1..3 parity are 0.
- NUM_PACKETS=3 with `pkt_valid` only for slot 1:
  - With the macro: island is 108 cycles, and slots 0 and 2 are null.
  - Without the macro: slot 0 is null, slot 1 carries data, island ends at 76 cycles.
- `start` pulsed while `busy` → no effect. `rst_n` low at packet k=10 → all outputs 0 within the same cycle, next `start` gives a clean island.
- hsync toggled during packet pixels → `ch0[0]` follows it with zero added latency.
